// File: rtl/ifq_defs.sv
// rtl/ifq_defs.sv - shared constants, entry layout and counter sizing for the fetch queue
package ifq_defs;

    localparam logic [31:0] IFQ_NOP     = 32'h0;
    localparam int          IFQ_ENTRY_W = 64;

    // Counters must represent 0..depth inclusive.
    function automatic int ifq_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// rtl/ifq_fifo.sv - synchronous FIFO of {instr, pc4} entries with wrap-bit pointers
module ifq_fifo
    import ifq_defs::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [IFQ_ENTRY_W-1:0] din,
    output logic                   full,
    output logic                   empty,
    output logic [CW-1:0]          count,
    output logic [IFQ_ENTRY_W-1:0] head
);

    logic [IFQ_ENTRY_W-1:0] mem [DEPTH];
    logic [CW-1:0]          wr_ptr;
    logic [CW-1:0]          rd_ptr;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == CW'(DEPTH));
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + CW'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + CW'(1);
        end
    end

    // Storage is not reset; the head is only consumed when the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/if_prefetch_queue.sv
// rtl/if_prefetch_queue.sv - credit-based instruction prefetch queue; IFQ_PERF_EN adds perf counters
module if_prefetch_queue
    import ifq_defs::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
`ifdef IFQ_PERF_EN
    output logic [31:0] perf_empty_cnt,
    output logic [31:0] perf_flush_cnt,
`endif
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_instr,
    output logic        instr_valid,
    output logic [31:0] instr_IF,
    output logic [31:0] PC_4_IF
);

    localparam int            CW         = ifq_cnt_w(DEPTH);
    localparam logic [CW:0]   CREDIT_MAX = (CW + 1)'(DEPTH);

    logic [31:0]            fetch_pc;
    logic [31:0]            rsp_pc;
    logic [31:0]            redirect_aligned;
    logic [CW-1:0]          outstanding;
    logic [CW-1:0]          outstanding_next;
    logic [CW-1:0]          drop_cnt;
    logic [CW-1:0]          occupancy;
    logic [CW:0]            credits_used;
    logic                   req_fire;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [IFQ_ENTRY_W-1:0] head;

    assign redirect_aligned = {redirect_pc[31:2], 2'b00};
    assign credits_used     = {1'b0, occupancy} + {1'b0, outstanding};

    // Every request reserves a queue slot, so a returning response can always be pushed.
    assign imem_req_valid = rst && !redirect_valid && (credits_used < CREDIT_MAX);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign push        = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
    assign instr_valid = !fifo_empty;
    assign pop         = instr_valid && !stall && !redirect_valid;
    assign instr_IF    = fifo_empty ? IFQ_NOP : head[63:32];
    assign PC_4_IF     = fifo_empty ? 32'h0   : head[31:0];

    always_comb begin
        outstanding_next = outstanding;
        if (req_fire)       outstanding_next = outstanding_next + CW'(1);
        if (imem_rsp_valid) outstanding_next = outstanding_next - CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc <= redirect_aligned;
                rsp_pc   <= redirect_aligned;
                drop_cnt <= outstanding_next;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + 32'd4;
                if (imem_rsp_valid) begin
                    if (drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
                    else                rsp_pc   <= rsp_pc + 32'd4;
                end
            end
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (redirect_valid),
        .din   ({imem_rsp_instr, rsp_pc + 32'd4}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occupancy),
        .head  (head)
    );

`ifdef IFQ_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_empty_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (!instr_valid && !stall && (perf_empty_cnt != '1))
                perf_empty_cnt <= perf_empty_cnt + 32'd1;
            if (redirect_valid && (perf_flush_cnt != '1))
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

    a_outstanding_bound: assert property (@(posedge clk) disable iff (!rst)
        outstanding <= CW'(DEPTH));
    a_drop_bound: assert property (@(posedge clk) disable iff (!rst)
        drop_cnt <= outstanding);
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && fifo_full));

endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb/tb_if_prefetch_queue.sv - directed self-checking bench for if_prefetch_queue
module tb_if_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_instr = 32'h0;
    logic        instr_valid;
    logic [31:0] instr_IF;
    logic [31:0] PC_4_IF;
`ifdef IFQ_PERF_EN
    logic [31:0] perf_empty_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    if_prefetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
`ifdef IFQ_PERF_EN
        .perf_empty_cnt (perf_empty_cnt),
        .perf_flush_cnt (perf_flush_cnt),
`endif
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_instr (imem_rsp_instr),
        .instr_valid    (instr_valid),
        .instr_IF       (instr_IF),
        .PC_4_IF        (PC_4_IF)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // In-order memory: each accepted request answers mem_lat cycles later unless held.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t mq[$];
    int    cyc      = 0;
    int    mem_lat  = 1;
    logic  mem_hold = 1'b0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            mq.delete();
        end else begin
            if (imem_rsp_valid) void'(mq.pop_front());
            if (imem_req_valid && imem_req_ready) mq.push_back('{imem_req_addr, cyc + mem_lat});
        end
        #1;
        if (!mem_hold && mq.size() > 0 && mq[0].due <= cyc + 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_instr = word_at(mq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_instr = 32'h0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic sm();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        stall          = 1'b0;
        imem_req_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    logic [31:0] exp_pc4;
    int          pops;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr_IF, 32'h0);
        chk("rst_pc4", PC_4_IF, 32'h0);
`ifdef IFQ_PERF_EN
        chk("rst_perf_flush", perf_flush_cnt, 32'd0);
        chk("rst_perf_empty", perf_empty_cnt, 32'd0);
`endif
        rst = 1'b1;

        // Sequential fetch, 1-cycle memory
        sm();
        chk("t1_req_valid0", {31'b0, imem_req_valid}, 32'd1);
        chk("t1_addr0", imem_req_addr, 32'h0);
        chk("t1_iv0", {31'b0, instr_valid}, 32'd0);
        nx(); sm();
        chk("t1_addr1", imem_req_addr, 32'h4);
        chk("t1_iv1", {31'b0, instr_valid}, 32'd0);
        nx(); sm();
        chk("t1_addr2", imem_req_addr, 32'h8);
        chk("t1_iv2", {31'b0, instr_valid}, 32'd1);
        chk("t1_pc4_2", PC_4_IF, 32'h4);
        chk("t1_instr2", instr_IF, word_at(32'h0));
        nx(); sm();
        chk("t1_addr3", imem_req_addr, 32'hC);
        chk("t1_pc4_3", PC_4_IF, 32'h8);

        // Stall: credits run out after DEPTH entries, head is held
        nx();
        stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) nx();
            sm();
            chk("t2_hold_pc4", PC_4_IF, 32'hC);
            chk("t2_hold_instr", instr_IF, word_at(32'h8));
            chk("t2_req_valid", {31'b0, imem_req_valid}, (i < 2) ? 32'd1 : 32'd0);
            if (i < 2) chk("t2_req_addr", imem_req_addr, 32'h10 + 32'(4 * i));
        end
        nx();
        stall = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (j > 0) nx();
            sm();
            if (j == 0) chk("t2_full_no_req", {31'b0, imem_req_valid}, 32'd0);
            chk("t2_drain_iv", {31'b0, instr_valid}, 32'd1);
            chk("t2_drain_pc4", PC_4_IF, 32'hC + 32'(4 * j));
            chk("t2_drain_instr", instr_IF, word_at(32'h8 + 32'(4 * j)));
        end

        // Redirect with two responses in flight
        mem_hold = 1'b1;
        do_reset();
        sm();
        nx(); sm();
        chk("t3_addr1", imem_req_addr, 32'h4);
        nx();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        sm();
        chk("t3_redirect_no_req", {31'b0, imem_req_valid}, 32'd0);
        mem_hold = 1'b0;
        nx();
        redirect_valid = 1'b0;
        sm();
        chk("t3_iv_after_redirect", {31'b0, instr_valid}, 32'd0);
        chk("t3_new_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("t3_new_req_addr", imem_req_addr, 32'h100);
        nx(); sm();
        chk("t3_drop0_iv", {31'b0, instr_valid}, 32'd0);
        chk("t3_addr_104", imem_req_addr, 32'h104);
        nx(); sm();
        chk("t3_drop1_iv", {31'b0, instr_valid}, 32'd0);
        nx(); sm();
        chk("t3_first_iv", {31'b0, instr_valid}, 32'd1);
        chk("t3_first_pc4", PC_4_IF, 32'h104);
        chk("t3_first_instr", instr_IF, word_at(32'h100));

        // Redirect coinciding with a response and a stall; low address bits ignored
        nx();
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        sm();
        chk("t4_no_req", {31'b0, imem_req_valid}, 32'd0);
        chk("t4_head_pc4", PC_4_IF, 32'h108);
        nx();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        sm();
        chk("t4_iv_cleared", {31'b0, instr_valid}, 32'd0);
        chk("t4_instr_nop", instr_IF, 32'h0);
        chk("t4_pc4_zero", PC_4_IF, 32'h0);
        chk("t4_new_addr", imem_req_addr, 32'h200);
        nx(); sm();
        chk("t4_drop_iv", {31'b0, instr_valid}, 32'd0);
        nx(); sm();
        chk("t4_first_iv", {31'b0, instr_valid}, 32'd1);
        chk("t4_first_pc4", PC_4_IF, 32'h204);
        chk("t4_first_instr", instr_IF, word_at(32'h200));

        // Random ready, random latency 1-3, random stall vs sequential reference
        nx();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1000;
        sm();
        nx();
        redirect_valid = 1'b0;
        exp_pc4 = 32'h1004;
        pops    = 0;
        for (int c = 0; c < 400; c++) begin
            imem_req_ready = 1'($urandom_range(0, 1));
            stall          = ($urandom_range(0, 3) == 0);
            sm();
            mem_lat = int'($urandom_range(1, 3));
            if (instr_valid && !stall) begin
                chk("t5_stream_pc4", PC_4_IF, exp_pc4);
                chk("t5_stream_instr", instr_IF, word_at(exp_pc4 - 32'd4));
                exp_pc4 = exp_pc4 + 32'd4;
                pops++;
            end
            nx();
        end
        chk("t5_pop_count_ok", (pops >= 40) ? 32'd1 : 32'd0, 32'd1);
        imem_req_ready = 1'b1;
        stall          = 1'b0;
        mem_lat        = 1;
        for (int c = 0; c < 8; c++) begin
            sm();
            if (instr_valid) begin
                chk("t5_drain_pc4", PC_4_IF, exp_pc4);
                exp_pc4 = exp_pc4 + 32'd4;
            end
            nx();
        end
`ifdef IFQ_PERF_EN
        chk("t5_perf_flush", perf_flush_cnt, 32'd3);
`endif

        // Asynchronous reset mid-burst
        sm();
        chk("t6_busy_iv", {31'b0, instr_valid}, 32'd1);
        nx();
        rst = 1'b0;
        #1;
        chk("t6_async_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("t6_async_iv", {31'b0, instr_valid}, 32'd0);
        chk("t6_async_instr", instr_IF, 32'h0);
        chk("t6_async_pc4", PC_4_IF, 32'h0);
`ifdef IFQ_PERF_EN
        chk("t6_async_perf_flush", perf_flush_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        sm();
        chk("t6_restart_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("t6_restart_addr", imem_req_addr, 32'h0);
        nx(); sm();
        nx(); sm();
        chk("t6_restart_iv", {31'b0, instr_valid}, 32'd1);
        chk("t6_restart_pc4", PC_4_IF, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
